stack_op_sequencer: RTL and testbench

STACK_OP_SEQUENCER -- requirements
Module: stack_op_sequencer

---
 rtl/stack_op_sequencer.sv | 171 +++++++++++++++++
 tb/tb_stack_op_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_op_sequencer.sv
// Command sequencer for an attached hardware stack: decodes stack-machine commands into
// fetch/store primitive sequences and tracks stack occupancy.
module stack_op_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 20,
  localparam int unsigned DW   = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_cmd,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_done,
  output logic             o_error,
  output logic [DW-1:0]    o_depth,
  output logic             o_fetch,
  output logic             o_store,
  output logic [2:0]       o_function,
  output logic [WIDTH-1:0] o_write_D,
  input  logic [WIDTH-1:0] i_read_A,
  input  logic [WIDTH-1:0] i_read_B
);

  localparam logic [2:0] CmdNop  = 3'b000;
  localparam logic [2:0] CmdPush = 3'b001;
  localparam logic [2:0] CmdDrop = 3'b010;
  localparam logic [2:0] CmdDup  = 3'b011;
  localparam logic [2:0] CmdSwap = 3'b100;
  localparam logic [2:0] CmdOver = 3'b101;

  localparam logic [2:0] FnPush        = 3'b000;
  localparam logic [2:0] FnPop         = 3'b001;
  localparam logic [2:0] FnReplTop     = 3'b010;
  localparam logic [2:0] FnReplSecond  = 3'b011;

  localparam logic [DW-1:0] Full = DW'(DEPTH);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StWrite1, StWrite2} state_e;

  state_e             state_q;
  logic               ready_q, done_q, error_q, fetch_q, store_q;
  logic [2:0]         func_q, cmd_q;
  logic [WIDTH-1:0]   wdata_q, a_q;
  logic [DW-1:0]      depth_q;
  logic               inc_q, dec_q;
  logic               cmd_err;

  logic is_empty, is_full, below_two;
  assign is_empty  = (depth_q == '0);
  assign is_full   = (depth_q == Full);
  assign below_two = (depth_q <= DW'(1));

  always_comb begin
    cmd_err = 1'b0;
    case (i_cmd)
      CmdNop:  cmd_err = 1'b0;
      CmdPush: cmd_err = is_full;
      CmdDrop: cmd_err = is_empty;
      CmdDup:  cmd_err = is_empty || is_full;
      CmdSwap: cmd_err = below_two;
      CmdOver: cmd_err = below_two || is_full;
      default: cmd_err = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      fetch_q <= 1'b0;
      store_q <= 1'b0;
      func_q  <= '0;
      wdata_q <= '0;
      depth_q <= '0;
      cmd_q   <= '0;
      a_q     <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state below re-asserts them.
      done_q  <= 1'b0;
      error_q <= 1'b0;
      fetch_q <= 1'b0;
      store_q <= 1'b0;
      func_q  <= '0;
      wdata_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            ready_q <= 1'b0;
            cmd_q   <= i_cmd;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            if (cmd_err || i_cmd == CmdNop) begin
              state_q <= StWrite1;
              done_q  <= 1'b1;
              error_q <= cmd_err;
            end else if (i_cmd == CmdPush) begin
              state_q <= StWrite1;
              done_q  <= 1'b1;
              store_q <= 1'b1;
              func_q  <= FnPush;
              wdata_q <= i_data;
              inc_q   <= 1'b1;
            end else if (i_cmd == CmdDrop) begin
              state_q <= StWrite1;
              done_q  <= 1'b1;
              store_q <= 1'b1;
              func_q  <= FnPop;
              dec_q   <= 1'b1;
            end else begin
              state_q <= StFetch;
              fetch_q <= 1'b1;
              inc_q   <= (i_cmd != CmdSwap);
            end
          end
        end
        StFetch: state_q <= StWait;
        StWait: begin
          a_q     <= i_read_A;
          state_q <= StWrite1;
          store_q <= 1'b1;
          if (cmd_q == CmdSwap) begin
            func_q  <= FnReplTop;
            wdata_q <= i_read_B;
          end else begin
            func_q  <= FnPush;
            wdata_q <= (cmd_q == CmdOver) ? i_read_B : i_read_A;
            done_q  <= 1'b1;
          end
        end
        StWrite1: begin
          // Only a successful SWAP is storing here without having completed.
          if (store_q && cmd_q == CmdSwap) begin
            state_q <= StWrite2;
            store_q <= 1'b1;
            func_q  <= FnReplSecond;
            wdata_q <= a_q;
            done_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            if (inc_q)      depth_q <= depth_q + DW'(1);
            else if (dec_q) depth_q <= depth_q - DW'(1);
          end
        end
        StWrite2: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready    = ready_q;
  assign o_done     = done_q;
  assign o_error    = error_q;
  assign o_fetch    = fetch_q;
  assign o_store    = store_q;
  assign o_function = func_q;
  assign o_write_D  = wdata_q;
  assign o_depth    = depth_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: attached stack model, queue-based reference, directed table,
// corner-case sequences and randomized commands.
module tb_stack_op_sequencer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 20;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [2:0]        i_cmd = '0;
  logic [WIDTH-1:0]  i_data = '0;
  logic              o_done, o_error, o_fetch, o_store;
  logic [4:0]        o_depth;
  logic [2:0]        o_function;
  logic [WIDTH-1:0]  o_write_D;
  logic [WIDTH-1:0]  i_read_A = '0;
  logic [WIDTH-1:0]  i_read_B = '0;

  stack_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready), .i_cmd(i_cmd),
    .i_data(i_data), .o_done(o_done), .o_error(o_error), .o_depth(o_depth),
    .o_fetch(o_fetch), .o_store(o_store), .o_function(o_function), .o_write_D(o_write_D),
    .i_read_A(i_read_A), .i_read_B(i_read_B)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endfunction

  // Attached stack driven only by the DUT strobes; read data is valid only after a fetch.
  logic [WIDTH-1:0] mem [0:31];
  int mem_cnt = 0;
  always @(posedge i_clk) begin
    if (i_reset) begin
      mem_cnt <= 0;
    end else begin
      if (o_fetch && mem_cnt > 0) i_read_A <= mem[mem_cnt-1];
      else                        i_read_A <= WIDTH'($urandom);
      if (o_fetch && mem_cnt > 1) i_read_B <= mem[mem_cnt-2];
      else                        i_read_B <= WIDTH'($urandom);
      if (o_store) begin
        case (o_function)
          3'd0: if (mem_cnt < 32) begin mem[mem_cnt] <= o_write_D; mem_cnt <= mem_cnt + 1; end
          3'd1: if (mem_cnt > 0) mem_cnt <= mem_cnt - 1;
          3'd2: if (mem_cnt > 0) mem[mem_cnt-1] <= o_write_D;
          3'd3: if (mem_cnt > 1) mem[mem_cnt-2] <= o_write_D;
          default: ;
        endcase
      end
    end
  end

  // Cycle-level protocol rules.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_fetch && o_store) check("fetch_store_overlap", 1, 0);
      if (!o_store && (o_function != 3'd0 || o_write_D != '0))
        check("idle_store_fields", int'(o_write_D) | int'(o_function), 0);
      if (o_error && !o_done) check("error_without_done", 0, 1);
    end
  end

  logic [WIDTH-1:0] ref_q[$];

  task automatic do_cmd(input logic [2:0] cmd, input logic [WIDTH-1:0] data,
                        input bit has_c, input bit c_err, input int c_depth);
    int d, exp_lat, exp_nf, nw, got_lat, nf, ns;
    bit err, gerr, mism;
    logic [WIDTH-1:0] a, b;
    int efn[2], ed[2], gfn[2], gd[2];
    bit echk[2];
    d = ref_q.size();
    a = (d > 0) ? ref_q[d-1] : '0;
    b = (d > 1) ? ref_q[d-2] : '0;
    err = (cmd > 3'd5) || ((cmd == 3'd2 || cmd == 3'd3) && d == 0) ||
          ((cmd == 3'd4 || cmd == 3'd5) && d < 2) ||
          ((cmd == 3'd1 || cmd == 3'd3 || cmd == 3'd5) && d == DEPTH);
    exp_lat = 1; exp_nf = 0; nw = 0;
    echk[0] = 1'b0; echk[1] = 1'b0; efn = '{0, 0}; ed = '{0, 0};
    if (!err) begin
      case (cmd)
        3'd1: begin nw = 1; efn[0] = 0; ed[0] = int'(data); echk[0] = 1; ref_q.push_back(data); end
        3'd2: begin nw = 1; efn[0] = 1; void'(ref_q.pop_back()); end
        3'd3: begin exp_lat = 3; exp_nf = 1; nw = 1; ed[0] = int'(a); echk[0] = 1;
                    ref_q.push_back(a); end
        3'd4: begin exp_lat = 4; exp_nf = 1; nw = 2; efn = '{2, 3}; ed = '{int'(b), int'(a)};
                    echk = '{1'b1, 1'b1}; ref_q[d-1] = b; ref_q[d-2] = a; end
        3'd5: begin exp_lat = 3; exp_nf = 1; nw = 1; ed[0] = int'(b); echk[0] = 1;
                    ref_q.push_back(b); end
        default: ;
      endcase
    end
    check("ready_before_cmd", int'(o_ready), 1);
    i_valid = 1'b1; i_cmd = cmd; i_data = data;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_cmd = 3'($urandom); i_data = WIDTH'($urandom);
    got_lat = 0; gerr = 1'b0; nf = 0; ns = 0; gfn = '{0, 0}; gd = '{0, 0};
    for (int c = 1; c <= 8; c++) begin
      if (o_fetch) nf++;
      if (o_store) begin
        if (ns < 2) begin gfn[ns] = int'(o_function); gd[ns] = int'(o_write_D); end
        ns++;
      end
      if (o_done) begin got_lat = c; gerr = o_error; break; end
      @(posedge i_clk); #1;
    end
    check("done_latency", got_lat, exp_lat);
    check("error_flag", int'(gerr), int'(err));
    check("fetch_count", nf, exp_nf);
    check("store_count", ns, nw);
    for (int i = 0; i < nw && i < ns; i++) begin
      check("store_function", gfn[i], efn[i]);
      if (echk[i]) check("store_data", gd[i], ed[i]);
    end
    if (has_c) check("table_error", int'(gerr), int'(c_err));
    @(posedge i_clk); #1;
    check("depth_after", int'(o_depth), ref_q.size());
    if (has_c) check("table_depth", int'(o_depth), c_depth);
    mism = (mem_cnt != ref_q.size());
    for (int i = 0; i < ref_q.size() && !mism; i++) mism = (mem[i] != ref_q[i]);
    check("stack_contents", int'(mism), 0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_ready", int'(o_ready), 1);
    check("rst_done", int'(o_done), 0);
    check("rst_error", int'(o_error), 0);
    check("rst_fetch", int'(o_fetch), 0);
    check("rst_store", int'(o_store), 0);
    check("rst_function", int'(o_function), 0);
    check("rst_write_D", int'(o_write_D), 0);
    check("rst_depth", int'(o_depth), 0);
    i_reset = 1'b0;
    ref_q.delete();
    @(posedge i_clk); #1;
  endtask

  typedef struct {
    logic [2:0]       cmd;
    logic [WIDTH-1:0] data;
    bit               err;
    int               depth;
  } vec_t;
  vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit strobed;
    vecs = '{
      '{3'b001, 16'h1234, 1'b0, 1},  // PUSH from reset
      '{3'b010, 16'h0000, 1'b0, 0},
      '{3'b010, 16'h0000, 1'b1, 0},  // DROP on empty
      '{3'b001, 16'h0001, 1'b0, 1},
      '{3'b001, 16'h0002, 1'b0, 2},
      '{3'b100, 16'h0000, 1'b0, 2},  // SWAP: top<-1, second<-2
      '{3'b000, 16'h0000, 1'b0, 2},
      '{3'b111, 16'h0000, 1'b1, 2},
      '{3'b110, 16'h0000, 1'b1, 2},
      '{3'b101, 16'h0000, 1'b0, 3},
      '{3'b011, 16'h0000, 1'b0, 4},
      '{3'b010, 16'h0000, 1'b0, 3}
    };
    do_reset();
    foreach (vecs[i]) do_cmd(vecs[i].cmd, vecs[i].data, 1'b1, vecs[i].err, vecs[i].depth);

    // Fill to capacity, reject DUP, then OVER at one below full.
    do_reset();
    for (int k = 0; k < DEPTH; k++) do_cmd(3'b001, WIDTH'(16'h0100 + k), 1'b1, 1'b0, k + 1);
    do_cmd(3'b011, '0, 1'b1, 1'b1, DEPTH);
    do_cmd(3'b010, '0, 1'b1, 1'b0, DEPTH - 1);
    do_cmd(3'b101, '0, 1'b1, 1'b0, DEPTH);

    // Reset during WAIT of a DUP aborts it with strobes cleared at once.
    do_reset();
    do_cmd(3'b001, 16'hbeef, 1'b1, 1'b0, 1);
    i_valid = 1'b1; i_cmd = 3'b011;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    check("abort_fetch_seen", int'(o_fetch), 1);
    @(posedge i_clk); #2;
    i_reset = 1'b1;
    #1;
    check("abort_ready", int'(o_ready), 1);
    check("abort_depth", int'(o_depth), 0);
    check("abort_done", int'(o_done), 0);
    strobed = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    ref_q.delete();
    for (int c = 0; c < 6; c++) begin
      if (o_fetch || o_store || o_done) strobed = 1'b1;
      @(posedge i_clk); #1;
    end
    check("abort_no_strobes", int'(strobed), 0);
    check("abort_ready_after", int'(o_ready), 1);

    // Randomized commands, PUSH weighted so the stack wanders through its range.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 10);
      do_cmd((r >= 8) ? 3'b001 : 3'(r), WIDTH'($urandom), 1'b0, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
